point_lsu: RTL and testbench
============================

# point_lsu

Wide-register load/store sequencer for the rv32i point extension. It moves one PWIDTH-bit point register to or from 32-bit word memory as a run of consecutive word beats. Each transfer uses one request/response handshake. The block owns the point register file, sits between the core's execute stage and the shared memory port, and generalises the fixed 256-bit `loadp` path with parametrised width, register count, stores, and memory wait states.

## Interface
Parameters:
- XLEN, 32, memory word and address width.
- PWIDTH, 256, point register width; must be a multiple of XLEN, so BEATS = PWIDTH/XLEN.
- NPREG, 8, number of point registers; index width RW = $clog2(NPREG).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  transfer request.
- req_ready  out  1  high only in IDLE.
- req_op  in  1  0 = load (memory to preg), 1 = store (preg to memory).
- req_addr  in  XLEN  byte base address.
- req_preg  in  RW  point register index.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse (see Configuration).
- rd_idx  in  RW  core read port index.
- rd_data  out  PWIDTH  combinational regfile read.
- mem_valid  out  1  beat request.
- mem_ready  in  1  beat accepted; read data valid in the same cycle.
- mem_we  out  1  write beat; only ever high together with mem_valid.
- mem_addr  out  XLEN  beat address.
- mem_wdata  out  XLEN  store data.
- mem_rdata  in  XLEN  load data, sampled when mem_valid && mem_ready.

## Operation
- FSM states: IDLE, XFER, COMMIT.
- IDLE -> XFER when req_valid && req_ready. On acceptance:
  - latch op, address, and preg;
  - clear beat counter i;
  - for a store, snapshot the whole preg into the shadow buffer.
- In XFER, each beat drives:
  - mem_addr = base + XLEN/8*i, modulo 2^XLEN (address wrap-around is allowed);
  - mem_valid = 1;
  - mem_we = op;
  - mem_wdata = shadow[XLEN*i +: XLEN].
- A beat completes on mem_valid && mem_ready. For a load, mem_rdata goes into shadow[XLEN*i +: XLEN]. The word at the lowest address lands in the LSBs.
- If mem_ready is low, the beat holds: address, data, and we stay stable.
- After beat BEATS-1 the FSM moves to COMMIT. In COMMIT:
  - a load writes the shadow buffer into regfile[preg];
  - done pulses;
  - the FSM returns to IDLE.
- A load updates the regfile atomically. rd_data shows the old value until the COMMIT edge.
- req_valid outside IDLE is ignored. The requester holds it.
- Reset, including during XFER:
  - FSM returns to IDLE and the counter clears;
  - all regfile entries clear to 0;
  - any partial load is discarded;
  - no further beats are issued.
- Output values during and right after reset: mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, req_ready=1.

## Timing
- Acceptance is at edge T. The first beat is presented in cycle T+1.
- With mem_ready tied high:
  - beats occupy cycles T+1..T+BEATS;
  - done is high in T+BEATS+1;
  - the loaded value is visible on rd_data from T+BEATS+2;
  - req_ready returns in T+BEATS+2.
- Each cycle with mem_ready low adds one cycle of latency.
- Back-to-back: the earliest next acceptance is in the cycle where req_ready has returned to 1.

## Configuration
- POINT_LSU_ALIGN_CHECK_EN defined:
  - a request with req_addr[1:0] != 0 is accepted but issues no beats;
  - err pulses in cycle T+1 and the FSM returns to IDLE;
  - the regfile and memory are untouched and done does not pulse.
- POINT_LSU_ALIGN_CHECK_EN undefined:
  - err is tied to 0;
  - low address bits pass through to mem_addr unchanged.

## Structure
- Shared package point_pkg holds:
  - XLEN/PWIDTH defaults;
  - the BEATS derivation;
  - the op encoding (OP_LOAD, OP_STORE);
  - the state enum (S_IDLE, S_XFER, S_COMMIT).
- One sub-module, point_regfile:
  - NPREG x PWIDTH;
  - one synchronous write port;
  - two combinational read ports (rd_idx, plus the internal store snapshot);
  - asynchronous clear.

## Test plan
- Load, zero wait: words 0x11111111..0x88888888 at byte 0x20..0x3C, load into p1 from 0x20. Expected:
  - mem_addr steps 0x20..0x3C over 8 cycles;
  - done pulses;
  - rd_data(1) = 0x88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111.
- Store: p1 holds the value above; store to 0x100. Expected: 8 beats with mem_we=1, words 0x11111111..0x88888888 written to 0x100..0x11C.
- Wait states: drop mem_ready for 2 cycles on beat 3 of a load. Expected:
  - mem_addr/mem_valid stay stable during the stall;
  - done arrives 2 cycles later;
  - the loaded value is unchanged versus the zero-wait case.
- Wrap: load from 0xFFFFFFF0. Expected addresses 0xFFFFFFF0, F4, F8, FC, then 0x0, 0x4, 0x8, 0xC.
- Reset mid-load: assert rst_n=0 after 4 beats. Expected:
  - mem_valid drops immediately;
  - the target preg reads 0 and req_ready=1 after release.
- Alignment, with POINT_LSU_ALIGN_CHECK_EN defined: load from 0x22. Expected:
  - err pulse at T+1;
  - no mem_valid;
  - preg unchanged.

Source files
------------

// File: rtl/point_pkg.sv
// Shared definitions for the point load/store unit: default widths, beat count
// derivation, transfer opcode encoding and sequencer states.
package point_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int PWIDTH_DEF = 256;
  localparam int NPREG_DEF  = 8;

  function automatic int point_beats(input int pwidth, input int xlen);
    return pwidth / xlen;
  endfunction

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_XFER   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/point_regfile.sv
// Point register file: NPREG x PWIDTH, one synchronous write port, two
// combinational read ports, asynchronous clear to zero.
module point_regfile #(
  parameter int PWIDTH = 256,
  parameter int NPREG  = 8,
  parameter int RW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [RW-1:0]     waddr,
  input  logic [PWIDTH-1:0] wdata,
  input  logic [RW-1:0]     ra_idx,
  output logic [PWIDTH-1:0] ra_data,
  input  logic [RW-1:0]     rb_idx,
  output logic [PWIDTH-1:0] rb_data
);

  logic [PWIDTH-1:0] regs_q [NPREG];
  logic [PWIDTH-1:0] regs_d [NPREG];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data = regs_q[ra_idx];
  assign rb_data = regs_q[rb_idx];

endmodule

// File: rtl/point_lsu.sv
// Wide point-register load/store sequencer: moves one PWIDTH register to/from
// XLEN-bit memory as BEATS word beats. Optional: POINT_LSU_ALIGN_CHECK_EN.
module point_lsu
  import point_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int PWIDTH = PWIDTH_DEF,
  parameter int NPREG  = NPREG_DEF,
  localparam int RW    = (NPREG > 1) ? $clog2(NPREG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [RW-1:0]     req_preg,
  output logic              done,
  output logic              err,
  input  logic [RW-1:0]     rd_idx,
  output logic [PWIDTH-1:0] rd_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int BEATS = point_beats(PWIDTH, XLEN);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [XLEN-1:0] BEAT_BYTES = XLEN'(XLEN / 8);
  localparam logic [CW-1:0]   LAST_BEAT  = CW'(BEATS - 1);

  state_e                     state_q, state_d;
  op_e                        op_q, op_d;
  logic [XLEN-1:0]            base_q, base_d;
  logic [RW-1:0]              preg_q, preg_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [BEATS-1:0][XLEN-1:0] shadow_q, shadow_d;
  logic [PWIDTH-1:0]          snap_data;
  logic                       in_xfer;
  logic                       rf_we;

`ifdef POINT_LSU_ALIGN_CHECK_EN
  logic err_q, err_d;
  logic misaligned;
  assign misaligned = (req_addr[1:0] != 2'b00);
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    base_d   = base_q;
    preg_d   = preg_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
`ifdef POINT_LSU_ALIGN_CHECK_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = op_e'(req_op);
          base_d  = req_addr;
          preg_d  = req_preg;
          cnt_d   = '0;
          state_d = S_XFER;
          if (op_e'(req_op) == OP_STORE) begin
            shadow_d = snap_data;
          end
`ifdef POINT_LSU_ALIGN_CHECK_EN
          // Misaligned requests are consumed without touching memory.
          if (misaligned) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
`endif
        end
      end
      S_XFER: begin
        if (mem_ready) begin
          if (op_q == OP_LOAD) begin
            shadow_d[cnt_q] = mem_rdata;
          end
          if (cnt_q == LAST_BEAT) begin
            state_d = S_COMMIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_LOAD;
      base_q   <= '0;
      preg_q   <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      base_q   <= base_d;
      preg_q   <= preg_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

`ifdef POINT_LSU_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // The regfile only changes at the COMMIT edge, so a load is seen atomically.
  assign rf_we = (state_q == S_COMMIT) && (op_q == OP_LOAD);

  point_regfile #(
    .PWIDTH(PWIDTH),
    .NPREG (NPREG),
    .RW    (RW)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (preg_q),
    .wdata  (shadow_q),
    .ra_idx (rd_idx),
    .ra_data(rd_data),
    .rb_idx (req_preg),
    .rb_data(snap_data)
  );

  assign in_xfer   = (state_q == S_XFER);
  assign req_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_COMMIT);
  assign mem_valid = in_xfer;
  assign mem_we    = in_xfer && (op_q == OP_STORE);
  assign mem_addr  = in_xfer ? (base_q + (XLEN'(cnt_q) * BEAT_BYTES)) : '0;
  assign mem_wdata = mem_we ? shadow_q[cnt_q] : '0;

endmodule

// File: tb/tb_point_lsu.sv
// Randomised self-checking bench for point_lsu against a word-level memory
// and register-file reference model.
module tb_point_lsu;

  localparam int XLEN   = 32;
  localparam int PWIDTH = 256;
  localparam int NPREG  = 8;
  localparam int BEATS  = PWIDTH / XLEN;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [XLEN-1:0]   req_addr;
  logic [2:0]        req_preg;
  logic              done;
  logic              err;
  logic [2:0]        rd_idx;
  logic [PWIDTH-1:0] rd_data;
  logic              mem_valid;
  logic              mem_ready = 1'b1;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  point_lsu #(.XLEN(XLEN), .PWIDTH(PWIDTH), .NPREG(NPREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_preg(req_preg),
    .done(done), .err(err),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model and reference register file.
  logic [31:0]       mem [logic [31:0]];
  logic [PWIDTH-1:0] ref_reg [NPREG];

  logic [31:0] beat_addr_q [$];
  logic [31:0] beat_data_q [$];
  logic        beat_we_q   [$];
  logic [31:0] cyc_addr_q  [$];
  int          stall_cycles = 0;
  int          beats_seen   = 0;
  int          stall_beat   = -1;
  int          stall_len    = 0;
  bit          rand_stall   = 1'b0;
  bit          err_seen     = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [PWIDTH-1:0] exp_load(input logic [31:0] base);
    logic [PWIDTH-1:0] v;
    logic [31:0]       a;
    v = '0;
    for (int i = 0; i < BEATS; i++) begin
      a = base + 32'(4 * i);
      v[32*i +: 32] = mem_word(a);
    end
    return v;
  endfunction

  // Memory responder: decides mem_ready mid-cycle and logs every beat.
  always @(negedge clk) begin
    if (err) err_seen = 1'b1;
    if (mem_valid) begin
      cyc_addr_q.push_back(mem_addr);
      if (rand_stall) begin
        mem_ready = ($urandom_range(0, 2) != 0);
      end else if (beats_seen == stall_beat && stall_len > 0) begin
        mem_ready = 1'b0;
        stall_len--;
      end else begin
        mem_ready = 1'b1;
      end
      mem_rdata = mem_word(mem_addr);
      if (!mem_ready) begin
        stall_cycles++;
      end else begin
        beat_addr_q.push_back(mem_addr);
        beat_data_q.push_back(mem_we ? mem_wdata : mem_rdata);
        beat_we_q.push_back(mem_we);
        beats_seen++;
        if (mem_we) mem[mem_addr] = mem_wdata;
      end
    end else begin
      mem_ready = 1'b1;
      mem_rdata = '0;
    end
  end

  task automatic clear_logs();
    beat_addr_q.delete();
    beat_data_q.delete();
    beat_we_q.delete();
    cyc_addr_q.delete();
    stall_cycles = 0;
    beats_seen   = 0;
    err_seen     = 1'b0;
  endtask

  // Issues one request (caller is at posedge+1 with the DUT idle) and returns
  // in the cycle where done is high; lat counts cycles after acceptance.
  task automatic run_xfer(input logic op, input logic [31:0] addr, input logic [2:0] preg,
                          output int lat, output bit timed_out);
    clear_logs();
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_preg  = preg;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat       = 0;
    timed_out = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      if (done) begin
        lat       = c;
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_addr = '0; req_preg = '0; rd_idx = '0;
    for (int i = 0; i < NPREG; i++) ref_reg[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    if ({mem_valid, mem_we, done, err} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl: got valid/we/done/err=%b want 0000", {mem_valid, mem_we, done, err});
    end
    total++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      bad++; $display("FAIL reset_mem: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    total++;
    rst_n = 1'b1;
    for (int i = 0; i < NPREG; i++) begin
      rd_idx = 3'(i);
      #1;
      if (rd_data !== ref_reg[i]) begin
        bad++; $display("FAIL reset_preg%0d: got %h want %h", i, rd_data, ref_reg[i]);
      end
      total++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_zero_wait();
    int lat; bit to;
    logic [PWIDTH-1:0] want;
    for (int k = 0; k < BEATS; k++) mem[32'h20 + 32'(4 * k)] = 32'h1111_1111 * 32'(k + 1);
    want = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
    rd_idx = 3'd1;
    run_xfer(1'b0, 32'h20, 3'd1, lat, to);
    if (to || lat != BEATS + 1) begin
      bad++; $display("FAIL load_latency: got %0d (timeout=%0d) want %0d", lat, to, BEATS + 1);
    end
    total++;
    if (rd_data !== ref_reg[1]) begin
      bad++; $display("FAIL load_atomic: got %h want old %h", rd_data, ref_reg[1]);
    end
    total++;
    if (cyc_addr_q.size() != BEATS) begin
      bad++; $display("FAIL load_beats: got %0d want %0d", cyc_addr_q.size(), BEATS);
    end else begin
      for (int i = 0; i < BEATS; i++) begin
        if (cyc_addr_q[i] !== 32'h20 + 32'(4 * i)) begin
          bad++; $display("FAIL load_addr%0d: got %h want %h", i, cyc_addr_q[i], 32'h20 + 32'(4 * i));
        end
        total++;
      end
    end
    total++;
    @(posedge clk); #1;
    ref_reg[1] = want;
    if (rd_data !== want) begin
      bad++; $display("FAIL load_value: got %h want %h", rd_data, want);
    end
    total++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL load_ready: got ready=%b done=%b want 1 0", req_ready, done);
    end
    total++;
  endtask

  task automatic test_store();
    int lat; bit to;
    run_xfer(1'b1, 32'h100, 3'd1, lat, to);
    if (to || lat != BEATS + 1) begin
      bad++; $display("FAIL store_latency: got %0d (timeout=%0d) want %0d", lat, to, BEATS + 1);
    end
    total++;
    if (beat_addr_q.size() != BEATS) begin
      bad++; $display("FAIL store_beats: got %0d want %0d", beat_addr_q.size(), BEATS);
    end else begin
      for (int i = 0; i < BEATS; i++) begin
        if (beat_we_q[i] !== 1'b1 || beat_addr_q[i] !== 32'h100 + 32'(4 * i)
            || beat_data_q[i] !== ref_reg[1][32*i +: 32]) begin
          bad++; $display("FAIL store_beat%0d: got we=%b addr=%h data=%h want 1 %h %h", i, beat_we_q[i],
                          beat_addr_q[i], beat_data_q[i], 32'h100 + 32'(4 * i), ref_reg[1][32*i +: 32]);
        end
        total++;
      end
    end
    total++;
    @(posedge clk); #1;
    if (rd_data !== ref_reg[1]) begin
      bad++; $display("FAIL store_preg: got %h want %h", rd_data, ref_reg[1]);
    end
    total++;
  endtask

  task automatic test_wait_states();
    int lat; bit to;
    logic [31:0] exp_cyc [$];
    for (int i = 0; i < BEATS; i++) begin
      exp_cyc.push_back(32'h20 + 32'(4 * i));
      if (i == 3) begin
        exp_cyc.push_back(32'h2C);
        exp_cyc.push_back(32'h2C);
      end
    end
    stall_beat = 3; stall_len = 2;
    rd_idx = 3'd2;
    run_xfer(1'b0, 32'h20, 3'd2, lat, to);
    stall_beat = -1;
    if (to || lat != BEATS + 3) begin
      bad++; $display("FAIL wait_latency: got %0d (timeout=%0d) want %0d", lat, to, BEATS + 3);
    end
    total++;
    if (cyc_addr_q.size() != exp_cyc.size()) begin
      bad++; $display("FAIL wait_cycles: got %0d want %0d", cyc_addr_q.size(), exp_cyc.size());
    end else begin
      for (int i = 0; i < exp_cyc.size(); i++) begin
        if (cyc_addr_q[i] !== exp_cyc[i]) begin
          bad++; $display("FAIL wait_addr%0d: got %h want %h", i, cyc_addr_q[i], exp_cyc[i]);
        end
        total++;
      end
    end
    total++;
    @(posedge clk); #1;
    ref_reg[2] = exp_load(32'h20);
    if (rd_data !== ref_reg[2]) begin
      bad++; $display("FAIL wait_value: got %h want %h", rd_data, ref_reg[2]);
    end
    total++;
  endtask

  task automatic test_wrap();
    int lat; bit to;
    logic [31:0] base;
    logic [31:0] a;
    base = 32'hFFFF_FFF0;
    rd_idx = 3'd3;
    run_xfer(1'b0, base, 3'd3, lat, to);
    if (to || beat_addr_q.size() != BEATS) begin
      bad++; $display("FAIL wrap_beats: got %0d (timeout=%0d) want %0d", beat_addr_q.size(), to, BEATS);
    end else begin
      for (int i = 0; i < BEATS; i++) begin
        a = base + 32'(4 * i);
        if (beat_addr_q[i] !== a) begin
          bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, beat_addr_q[i], a);
        end
        total++;
      end
    end
    total++;
    @(posedge clk); #1;
    ref_reg[3] = exp_load(base);
    if (rd_data !== ref_reg[3]) begin
      bad++; $display("FAIL wrap_value: got %h want %h", rd_data, ref_reg[3]);
    end
    total++;
  endtask

  task automatic test_reset_mid_load();
    bit reached;
    clear_logs();
    rd_idx = 3'd1;
    req_valid = 1'b1; req_op = 1'b0; req_addr = 32'h40; req_preg = 3'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (beat_addr_q.size() >= 4) begin
        reached = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!reached) begin
      bad++; $display("FAIL midrst_wait: got %0d beats want 4", beat_addr_q.size());
    end
    total++;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NPREG; i++) ref_reg[i] = '0;
    if (mem_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_immediate: got valid=%b ready=%b want 0 1", mem_valid, req_ready);
    end
    total++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (rd_data !== ref_reg[1] || req_ready !== 1'b1 || mem_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_after: got preg=%h ready=%b valid=%b want 0 1 0", rd_data, req_ready, mem_valid);
    end
    total++;
    if (beat_addr_q.size() != 4) begin
      bad++; $display("FAIL midrst_nobeats: got %0d beats want 4", beat_addr_q.size());
    end
    total++;
  endtask

  task automatic test_misaligned();
    int lat; bit to;
    lat = 0; to = 1'b0;
    rd_idx = 3'd5;
    run_xfer(1'b0, 32'h40, 3'd5, lat, to);
    @(posedge clk); #1;
    ref_reg[5] = exp_load(32'h40);
`ifdef POINT_LSU_ALIGN_CHECK_EN
    clear_logs();
    req_valid = 1'b1; req_op = 1'b0; req_addr = 32'h22; req_preg = 3'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (err !== 1'b1 || mem_valid !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL align_pulse: got err=%b valid=%b done=%b want 1 0 0", err, mem_valid, done);
    end
    total++;
    repeat (BEATS + 2) @(posedge clk);
    #1;
    if (err !== 1'b0 || req_ready !== 1'b1 || cyc_addr_q.size() != 0) begin
      bad++; $display("FAIL align_quiet: got err=%b ready=%b beats=%0d want 0 1 0", err, req_ready, cyc_addr_q.size());
    end
    total++;
`else
    run_xfer(1'b0, 32'h22, 3'd5, lat, to);
    if (to || err_seen || beat_addr_q.size() != BEATS) begin
      bad++; $display("FAIL unaligned_xfer: got beats=%0d err=%0d timeout=%0d want %0d 0 0",
                      beat_addr_q.size(), err_seen, to, BEATS);
    end else if (beat_addr_q[0] !== 32'h22 || beat_addr_q[BEATS-1] !== 32'h3E) begin
      bad++; $display("FAIL unaligned_xfer: got first=%h last=%h want 22 3e", beat_addr_q[0], beat_addr_q[BEATS-1]);
    end
    total++;
    @(posedge clk); #1;
    ref_reg[5] = exp_load(32'h22);
`endif
    if (rd_data !== ref_reg[5]) begin
      bad++; $display("FAIL align_preg: got %h want %h", rd_data, ref_reg[5]);
    end
    total++;
  endtask

  task automatic test_back_to_back_random();
    int lat; bit to;
    logic        op;
    logic [2:0]  preg;
    logic [31:0] base, a;
    logic [PWIDTH-1:0] want;
    rand_stall = 1'b1;
    for (int n = 0; n < 14; n++) begin
      op   = 1'($urandom_range(0, 1));
      preg = 3'($urandom_range(0, NPREG - 1));
      base = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) base = 32'hFFFF_FFE0 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) base = 32'h100;
      rd_idx = preg;
      want = (op == 1'b0) ? exp_load(base) : ref_reg[preg];
      if (req_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_ready%0d: got %b want 1", n, req_ready);
      end
      total++;
      run_xfer(op, base, preg, lat, to);
      if (to || lat != BEATS + 1 + stall_cycles) begin
        bad++; $display("FAIL rnd_latency%0d: got %0d (timeout=%0d) want %0d", n, lat, to, BEATS + 1 + stall_cycles);
      end
      total++;
      if (beat_addr_q.size() != BEATS) begin
        bad++; $display("FAIL rnd_beats%0d: got %0d want %0d", n, beat_addr_q.size(), BEATS);
      end else begin
        for (int i = 0; i < BEATS; i++) begin
          a = base + 32'(4 * i);
          if (beat_addr_q[i] !== a || beat_we_q[i] !== op
              || (op == 1'b1 && beat_data_q[i] !== ref_reg[preg][32*i +: 32])) begin
            bad++; $display("FAIL rnd_beat%0d_%0d: got addr=%h we=%b data=%h want %h %b %h", n, i,
                            beat_addr_q[i], beat_we_q[i], beat_data_q[i], a, op, ref_reg[preg][32*i +: 32]);
          end
          total++;
        end
      end
      total++;
      @(posedge clk); #1;
      ref_reg[preg] = want;
      if (rd_data !== want) begin
        bad++; $display("FAIL rnd_preg%0d: got %h want %h", n, rd_data, want);
      end
      total++;
    end
    rand_stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_zero_wait();
    test_store();
    test_wait_states();
    test_wrap();
    test_reset_mid_load();
    test_misaligned();
    test_back_to_back_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
